store_buffer: RTL

- Write buffer sitting between the EX/MEM pipeline register and the data memory.
- Stores from the pipeline are queued in a small FIFO and drained to memory in cycles where no load needs the memory port, so stores never stall the pipeline.
- Loads go straight to memory unless they hit a pending buffered store; on a hit the pipeline stalls until that store has drained.
- A fence input forces a full drain.

---
 rtl/store_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM pipeline register and a single-port data memory.
// Latency: loads issue combinationally in the request cycle; a buffered store drains
// one or more cycles after it is enqueued. Stalls only on a load hit or an active fence.
module store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [DM_ADDRESS-1:0]   req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [2:0]              req_funct3,
  input  logic                    fence,
  output logic                    stall,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DM_ADDRESS-1:0]   mem_a,
  output logic [DATA_W-1:0]       mem_wd,
  output logic [2:0]              mem_funct3,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage; validity is implied by head/count, so entries need no reset.
  logic [DM_ADDRESS-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0]     wdata_q [DEPTH];
  logic [2:0]            f3_q    [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic is_load;
  logic fence_blk;
  logic hit;
  logic load_issue;
  logic drain;
  logic enq;

  // Word-address match against every valid entry; byte offset ignored on purpose.
  always_comb begin
    logic [PW-1:0] off;
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) &&
          (addr_q[i][DM_ADDRESS-1:2] == req_addr[DM_ADDRESS-1:2])) begin
        hit = 1'b1;
      end
    end
  end

  // Request decode and single-port arbitration: an unblocked load wins, else drain the head.
  always_comb begin
    is_load    = req_read && !req_write;   // read+write together is treated as a store
    fence_blk  = fence && (count_q != '0);
    load_issue = !reset && is_load && !fence_blk && !hit;
    drain      = !reset && !load_issue && (count_q != '0);
    enq        = !reset && req_write && !fence_blk;
    stall      = !reset && (fence_blk || (is_load && hit));
  end

  // Memory port drive; everything held at zero when idle or in reset.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = 3'b000;
    if (load_issue) begin
      mem_read   = 1'b1;
      mem_a      = req_addr;
      mem_funct3 = req_funct3;
    end else if (drain) begin
      mem_write  = 1'b1;
      mem_a      = addr_q[head_q];
      mem_wd     = wdata_q[head_q];
      mem_funct3 = f3_q[head_q];
    end
  end

  // Pointer and occupancy next-state; a full buffer always drains, so enqueue reuses the slot.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + PW'(1);
    if (enq)   tail_d = tail_q + PW'(1);
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Capture an accepted store at the tail slot.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]  <= req_addr;
      wdata_q[tail_q] <= req_wdata;
      f3_q[tail_q]    <= req_funct3;
    end
  end

  assign count = reset ? '0 : count_q;
  assign empty = reset || (count_q == '0);

endmodule
